// File: rtl/xcore_boot_loader.sv
// Boot loader: streams an image into the core's RAM, holds the core in reset
// for a fixed time after the last word, then releases it.
module xcore_boot_loader #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 14,
    parameter int RST_HOLD_CYC = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic                s_valid,
    input  logic [DATA_W-1:0]   s_data,
    input  logic                s_last,
    output logic                s_ready,
    output logic                ram_we,
    output logic [DATA_W/8-1:0] ram_be,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    output logic                core_rst_n,
    output logic                done,
    output logic                err,
    output logic [ADDR_W:0]     word_cnt,
    output logic [DATA_W-1:0]   checksum
);

    localparam int HOLD_W = (RST_HOLD_CYC > 1) ? $clog2(RST_HOLD_CYC) : 1;
    localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYC - 1);

    typedef enum logic [2:0] {IDLE, LOAD, HOLD, RUN, ERR} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   ptr;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                accept;
    logic                at_top;
    logic                hold_end;

    assign s_ready  = (state == LOAD);
    assign accept   = s_valid && s_ready;
    assign at_top   = (ptr == ADDR_MAX);
    assign hold_end = (hold_cnt == HOLD_LAST);

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: next state defaults to the current state first, so no path infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = LOAD;
            LOAD: begin
                if (accept) begin
                    if (s_last)      state_nxt = HOLD;
                    else if (at_top) state_nxt = ERR;
                end
            end
            HOLD:    if (hold_end) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            ERR:     state_nxt = ERR;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the write-port data/address flops are reset too, so the RAM port reads all-zero in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= '0;
            hold_cnt   <= '0;
            ram_we     <= 1'b0;
            ram_be     <= '0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            core_rst_n <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            word_cnt   <= '0;
            checksum   <= '0;
        end else begin
            ram_we <= accept;
            ram_be <= accept ? '1 : '0;

            if (state == IDLE && start) begin
                ptr      <= base_addr;
                word_cnt <= '0;
                checksum <= '0;
            end

            if (accept) begin
                ram_addr  <= ptr;
                ram_wdata <= s_data;
                // The pointer saturates at the top word instead of wrapping.
                ptr       <= at_top ? ptr : ptr + 1'b1;
                word_cnt  <= word_cnt + 1'b1;
                checksum  <= checksum + s_data;
            end

            if (state == LOAD && state_nxt == HOLD)
                hold_cnt <= '0;
            else if (state == HOLD && !hold_end)
                hold_cnt <= hold_cnt + 1'b1;

            if (state == HOLD && hold_end) begin
                core_rst_n <= 1'b1;
                done       <= 1'b1;
            end

            if (state == LOAD && state_nxt == ERR)
                err <= 1'b1;
        end
    end

endmodule

// File: doc/xcore_boot_loader.md
XCORE_BOOT_LOADER -- requirements
Module: xcore_boot_loader

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the RAM word and stream data width, a multiple of 8.
REQ-002 The block SHALL have parameter ADDR_W, default 14, meaning the word-address width of the target RAM.
REQ-003 The block SHALL have parameter RST_HOLD_CYC, default 20, meaning the number of clk cycles the core stays in reset after the last word is written, with a minimum of 1.
REQ-004 clk  input  1  single clock; all logic SHALL be rising-edge clocked.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 start  input  1  one-cycle pulse that begins a load; honoured only in IDLE.
REQ-007 base_addr  input  ADDR_W  first RAM word address, sampled on the accepted start.
REQ-008 s_valid / s_data / s_last  input  1 / DATA_W / 1  image stream: word valid, word data, final word.
REQ-009 s_ready  output  1  stream ready signal; equals (state==LOAD), combinational.
REQ-010 ram_we / ram_be / ram_addr / ram_wdata  output  1 / DATA_W/8 / ADDR_W / DATA_W  registered RAM write port.
REQ-011 core_rst_n  output  1  active-low reset to the core, registered.
REQ-012 done / err  output  1 / 1  load complete with core released / address overflow.
REQ-013 word_cnt  output  ADDR_W+1  count of words accepted since the last start.
REQ-014 checksum  output  DATA_W  modulo-2^DATA_W sum of accepted words since the last start.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD, HOLD, RUN, ERR.
REQ-016 IDLE->LOAD SHALL occur on start; the same edge SHALL load the address pointer with base_addr and clear word_cnt and checksum.
REQ-017 A word SHALL be accepted only when s_valid and s_ready are both 1 on the same edge.
REQ-018 Each accepted word SHALL produce exactly one write on the next cycle: ram_we=1, ram_be all ones, ram_addr=pointer, ram_wdata=s_data (latency 1).
REQ-019 After each accept the pointer SHALL increment by 1, word_cnt SHALL increment by 1, and checksum SHALL add the word.
REQ-020 An accept with s_last=1 SHALL cause LOAD->HOLD and clear the hold counter.
REQ-021 HOLD SHALL last exactly RST_HOLD_CYC cycles and then transition to RUN.
REQ-022 On entering RUN, core_rst_n and done SHALL both become 1 and SHALL stay 1 until rst.
REQ-023 An accept at pointer==2^ADDR_W-1 with s_last=0 SHALL write that word, then cause LOAD->ERR with err=1; the pointer SHALL NOT wrap.
REQ-024 An accept at pointer==2^ADDR_W-1 with s_last=1 SHALL be legal and SHALL go to HOLD.
REQ-025 ERR SHALL be terminal until rst, with core_rst_n=0 and s_ready=0.
REQ-026 start SHALL be ignored in LOAD, HOLD, RUN and ERR.
REQ-027 s_valid SHALL be ignored outside LOAD.
REQ-028 s_valid low in LOAD SHALL stall the load with no write and no timeout.
REQ-029 ram_we SHALL be 0 in every cycle that does not follow an accept.

Reset
REQ-030 While rst=1 at a clock edge, the block SHALL enter IDLE and drive s_ready=0, ram_we=0, ram_be=0, ram_addr=0, ram_wdata=0, core_rst_n=0, done=0, err=0, word_cnt=0, checksum=0.
REQ-031 rst asserted during LOAD or HOLD SHALL abort the load with no further RAM writes from the cycle after the reset edge; a fresh start SHALL then be required.

Verification
REQ-032 Scenario: base_addr=0x100, start, 4 back-to-back words 0x11,0x22,0x33,0x44 with last on the 4th -> writes to 0x100..0x103 one cycle after each accept; word_cnt=4; checksum=0xAA; core_rst_n rises exactly 20 cycles after HOLD entry; done=1.
REQ-033 Scenario: same stream with s_valid deasserted for 3 cycles between words 2 and 3 -> no writes during the gap; final memory, word_cnt and checksum identical to REQ-032.
REQ-034 Scenario: base_addr=0x3FFE (ADDR_W=14), 3 words with none marked last -> writes to 0x3FFE and 0x3FFF; err=1; third word not accepted; s_ready=0; core_rst_n stays 0.
REQ-035 Scenario: base_addr=0x3FFF, one word with s_last=1 -> single write at 0x3FFF; HOLD then RUN; err=0.
REQ-036 Scenario: rst pulsed 2 cycles after LOAD entry, then start pulsed during RUN of a second load -> first load: no writes after the reset edge; second load: the start pulse in RUN is ignored and done stays 1.
REQ-037 Scenario: DATA_W=64, RST_HOLD_CYC=1 -> ram_be=0xFF on writes; core_rst_n rises 1 cycle after HOLD entry.
